// File: rtl/i2s_frame_tx.sv
// Serializes one row frame for the i2s_mask array: a 16-bit header, then (nx+1)*(ny+1)
// payload words, MSB first, with a clock enable that stalls the gated bit clock.
module i2s_frame_tx #(
  parameter int HDR_W  = 16,
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        num_modules_x,
  input  logic [3:0]        num_modules_y,
  input  logic [5:0]        row_num,
  input  logic [WORD_W-1:0] pld_data,
  input  logic              pld_valid,
  output logic              pld_ready,
  output logic              i2s_data,
  output logic              i2s_clk_en,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       stall_cnt
);

  // Payload handshake: a word is taken on any rising edge where pld_valid && pld_ready.
  // pld_ready depends only on state/counters, never on pld_valid.

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, WAIT, DONE} state_t;

  localparam logic [3:0] BIT_LAST = 4'(WORD_W - 1);

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [3:0]        bit_cnt;
  logic [8:0]        words_left;

  logic [HDR_W-1:0]  header;
  logic [4:0]        nx_p1;
  logic [4:0]        ny_p1;
  logic [8:0]        total_words;
  logic              last_word;

  assign header      = {num_modules_x, num_modules_y, 2'b00, row_num};
  assign nx_p1       = {1'b0, num_modules_x} + 5'd1;
  assign ny_p1       = {1'b0, num_modules_y} + 5'd1;
  assign total_words = {4'b0, nx_p1} * {4'b0, ny_p1};
  assign last_word   = (state == PAYLOAD) && (words_left == 9'd1);

  // Prefetch window: bit 0 of the header or of a non-final word, plus all of WAIT.
  assign pld_ready = (state == WAIT) ||
                     ((bit_cnt == 4'd0) &&
                      ((state == HEADER) || ((state == PAYLOAD) && (words_left != 9'd1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      words_left <= '0;
      i2s_data   <= 1'b0;
      i2s_clk_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          i2s_clk_en <= 1'b0;
          i2s_data   <= 1'b0;
          busy       <= 1'b0;
          if (start) begin
            i2s_data   <= header[HDR_W-1];
            sr         <= {header[HDR_W-2:0], 1'b0};
            bit_cnt    <= BIT_LAST;
            words_left <= total_words;
            stall_cnt  <= '0;
            busy       <= 1'b1;
            i2s_clk_en <= 1'b1;
            state      <= HEADER;
          end
        end

        HEADER, PAYLOAD: begin
          if (bit_cnt != 4'd0) begin
            i2s_data <= sr[WORD_W-1];
            sr       <= {sr[WORD_W-2:0], 1'b0};
            bit_cnt  <= bit_cnt - 4'd1;
          end else begin
            if (state == PAYLOAD) words_left <= words_left - 9'd1;
            if (last_word) begin
              i2s_clk_en <= 1'b0;
              i2s_data   <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else if (pld_valid) begin
              i2s_data   <= pld_data[WORD_W-1];
              sr         <= {pld_data[WORD_W-2:0], 1'b0};
              bit_cnt    <= BIT_LAST;
              i2s_clk_en <= 1'b1;
              state      <= PAYLOAD;
            end else begin
              i2s_clk_en <= 1'b0;
              state      <= WAIT;
            end
          end
        end

        WAIT: begin
          // i2s_data keeps the last bit so the stalled line does not toggle.
          i2s_clk_en <= 1'b0;
          if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
          if (pld_valid) begin
            i2s_data   <= pld_data[WORD_W-1];
            sr         <= {pld_data[WORD_W-2:0], 1'b0};
            bit_cnt    <= BIT_LAST;
            i2s_clk_en <= 1'b1;
            state      <= PAYLOAD;
          end
        end

        DONE: begin
          i2s_clk_en <= 1'b0;
          i2s_data   <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_frame_tx.sv
// Bench for i2s_frame_tx: a bit-stream model (header + accepted words as a bit queue)
// is checked against every DUT output each cycle, plus literal frame-level expectations.
module tb_i2s_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_modules_x = '0;
  logic [3:0]  num_modules_y = '0;
  logic [5:0]  row_num = '0;
  logic [15:0] pld_data = '0;
  logic        pld_valid = 1'b0;
  logic        pld_ready;
  logic        i2s_data;
  logic        i2s_clk_en;
  logic        busy;
  logic        frame_done;
  logic [15:0] stall_cnt;

  i2s_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_modules_x(num_modules_x), .num_modules_y(num_modules_y), .row_num(row_num),
    .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .i2s_data(i2s_data), .i2s_clk_en(i2s_clk_en), .busy(busy),
    .frame_done(frame_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: the frame as a flat bit queue and the index of the bit on the line.
  bit          m_busy, m_en, m_data, m_done, m_wait;
  int          m_cur, m_total;
  logic [15:0] m_stall;
  bit          m_bits[$];

  logic [15:0] src_q[$];
  int          popped, hold_left, mode;
  bit          cap[$];
  bit          ref_cap[$];
  int          en_cnt, done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return m_wait || (m_en && (m_cur % 16 == 15) && (m_cur + 1 < m_total));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_en = 0; m_data = 0; m_done = 0; m_wait = 0;
    m_cur = 0; m_total = 0; m_stall = '0;
    m_bits.delete();
  endtask

  task automatic push_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) m_bits.push_back(w[i]);
  endtask

  task automatic take_word();
    push_word(pld_data);
    void'(src_q.pop_front());
    popped++;
    m_cur++;
    m_data = m_bits[m_cur];
    m_en = 1;
  endtask

  // Advance the model by one rising edge using the inputs that were applied for that edge.
  task automatic model_step();
    bit r;
    r = model_ready();
    if (!rst_n) begin
      model_reset();
    end else if (m_done) begin
      m_done = 0; m_busy = 0; m_data = 0; m_en = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_bits.delete();
        push_word({num_modules_x, num_modules_y, 2'b00, row_num});
        m_total = 16 + 16 * (int'(num_modules_x) + 1) * (int'(num_modules_y) + 1);
        m_cur = 0; m_data = m_bits[0]; m_en = 1; m_busy = 1; m_stall = '0; m_wait = 0;
      end
    end else if (m_en) begin
      if (m_cur == m_total - 1) begin
        m_done = 1; m_en = 0; m_data = 0;
      end else if (r) begin
        if (pld_valid) take_word();
        else begin m_wait = 1; m_en = 0; end
      end else begin
        m_cur++;
        m_data = m_bits[m_cur];
      end
    end else if (m_wait) begin
      if (m_stall != 16'hFFFF) m_stall++;
      if (pld_valid) begin
        take_word();
        m_wait = 0;
      end
    end
  endtask

  task automatic drive_inputs();
    pld_data = (src_q.size() > 0) ? src_q[0] : 16'hDEAD;
    if (src_q.size() == 0) pld_valid = 1'b0;
    else if (mode == 1) pld_valid = ($urandom_range(0, 3) != 0);
    else if (mode == 2 && popped == 6 && model_ready() && hold_left > 0) begin
      pld_valid = 1'b0;
      hold_left--;
    end else pld_valid = 1'b1;
  endtask

  // One cycle: compare on the falling edge, then step the model on the rising edge.
  task automatic tick();
    @(negedge clk);
    chk("busy", busy, m_busy);
    chk("i2s_clk_en", i2s_clk_en, m_en);
    chk("i2s_data", i2s_data, m_data);
    chk("pld_ready", pld_ready, model_ready());
    chk("frame_done", frame_done, m_done);
    chk("stall_cnt", stall_cnt, m_stall);
    if (i2s_clk_en === 1'b1) begin cap.push_back(i2s_data); en_cnt++; end
    if (frame_done === 1'b1) done_cnt++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [15:0] cap_word(input int first);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < 16; i++) if (first + i < cap.size()) w[15-i] = cap[first+i];
    return w;
  endfunction

  task automatic run_frame(input logic [3:0] nx, input logic [3:0] ny, input logic [5:0] row,
                           input int mode_i, input logic [15:0] exp_hdr, input int exp_en,
                           input int exp_stall, input bit inject);
    int n_words, cyc;
    n_words = (int'(nx) + 1) * (int'(ny) + 1);
    src_q.delete();
    for (int i = 0; i < n_words; i++)
      src_q.push_back((mode_i == 1) ? 16'($urandom) : 16'(i + 1));
    mode = mode_i; popped = 0; hold_left = 6;
    cap.delete(); en_cnt = 0; done_cnt = 0;
    num_modules_x = nx; num_modules_y = ny; row_num = row; start = 1'b1;
    drive_inputs();
    tick();
    start = 1'b0;
    cyc = 0;
    while (!m_done && cyc < 20000) begin
      if (inject && m_en && m_cur == 100) begin
        start = 1'b1; num_modules_x = 4'd1; num_modules_y = 4'd2; row_num = 6'd9;
      end else start = 1'b0;
      drive_inputs();
      tick();
      cyc++;
    end
    if (!m_done) chk("frame_timeout", 1, 0);
    // A start on the DONE cycle must be dropped.
    start = 1'b1; num_modules_x = 4'd7; num_modules_y = 4'd2; row_num = 6'd33;
    drive_inputs();
    tick();
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("header_bits", cap_word(0), exp_hdr);
    chk("enabled_cycles", en_cnt, exp_en);
    chk("done_pulses", done_cnt, 1);
    chk("stall_cnt_end", stall_cnt, (exp_stall < 0) ? m_stall : 16'(exp_stall));
  endtask

  initial begin
    int diffs, guard;
    model_reset();
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_clk_en", i2s_clk_en, 0);
    chk("rst_ready", pld_ready, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;
    repeat (2) begin pld_valid = 1'b1; tick(); end

    // 4x4 row, no stalls.
    run_frame(4'd3, 4'd3, 6'd0, 0, 16'h3300, 272, 0, 0);
    chk("word1", cap_word(16), 16'h0001);
    chk("word16", cap_word(256), 16'h0010);
    ref_cap = cap;

    // Same frame with a six-cycle hole before word 7; bit stream must not change.
    run_frame(4'd3, 4'd3, 6'd0, 2, 16'h3300, 272, 6, 0);
    diffs = (cap.size() == ref_cap.size()) ? 0 : 1;
    for (int i = 0; i < cap.size() && i < ref_cap.size(); i++) if (cap[i] != ref_cap[i]) diffs++;
    chk("stall_stream_same", diffs, 0);

    // Single-module frame.
    run_frame(4'd0, 4'd0, 6'd63, 0, 16'h003F, 32, 0, 0);

    // Largest frame with random source gaps.
    run_frame(4'd15, 4'd15, 6'd5, 1, 16'hFF05, 4112, -1, 0);

    // Start mid-payload is ignored; the next frame starts on the cycle after DONE.
    run_frame(4'd3, 4'd3, 6'd2, 1, 16'h3302, 272, -1, 1);
    run_frame(4'd3, 4'd3, 6'd1, 0, 16'h3301, 272, 0, 0);

    // Reset during payload word 3.
    src_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(16'(i + 1));
    mode = 0; popped = 0; cap.delete();
    num_modules_x = 4'd3; num_modules_y = 4'd3; row_num = 6'd4; start = 1'b1;
    drive_inputs();
    tick();
    start = 1'b0;
    guard = 0;
    while (!(m_en && m_cur == 16 + 2 * 16 + 5) && guard < 200) begin
      drive_inputs(); tick(); guard++;
    end
    chk("reached_word3", (m_en && m_cur == 16 + 2 * 16 + 5), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_busy", busy, 0);
    chk("arst_clk_en", i2s_clk_en, 0);
    chk("arst_data", i2s_data, 0);
    chk("arst_ready", pld_ready, 0);
    chk("arst_done", frame_done, 0);
    chk("arst_stall", stall_cnt, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin drive_inputs(); tick(); end
    chk("no_done_after_reset", done_cnt, 0);
    chk("idle_after_reset", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
